// File: rtl/morse_key_classifier.sv
// Morse key classifier: synchronises and debounces a raw key, times each
// press into a DOT or DASH pulse, and times the idle gaps between presses
// into LETTER_END and WORD_END pulses.
//
// Ports:
//   CLK        - clock
//   RESET      - asynchronous, active-high reset
//   PB         - raw key input, asynchronous to CLK
//   DPB        - debounced key level, high while PRESSED or HELD
//   DOT        - one-cycle pulse, short press released
//   DASH       - one-cycle pulse, long press released
//   LETTER_END - one-cycle pulse, letter gap elapsed after a symbol
//   WORD_END   - one-cycle pulse, word gap elapsed after a symbol
//   CANCEL     - one-cycle pulse, release from HELD (optional feature)
//   BUSY       - high when not IDLE or when a gap event is pending
//
// Optional feature macro: MORSE_HOLD_CANCEL_EN
//   defined   - release from HELD emits CANCEL and drops pending gap events
//   undefined - release from HELD emits DASH, CANCEL is tied 0
//
// Every *_CYC threshold must be below 2**CNT_W, with
// DEBOUNCE_CYC < DOT_MAX_CYC < HOLD_MAX_CYC and
// DEBOUNCE_CYC < LETTER_GAP_CYC < WORD_GAP_CYC.

module morse_key_classifier #(
    parameter int CNT_W          = 28,
    parameter int DEBOUNCE_CYC   = 8388608,
    parameter int DOT_MAX_CYC    = 16777216,
    parameter int HOLD_MAX_CYC   = 33554432,
    parameter int LETTER_GAP_CYC = 16777216,
    parameter int WORD_GAP_CYC   = 67108864
) (
    input  logic CLK,
    input  logic RESET,
    input  logic PB,
    output logic DPB,
    output logic DOT,
    output logic DASH,
    output logic LETTER_END,
    output logic WORD_END,
    output logic CANCEL,
    output logic BUSY
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DEB     = 3'd1;
    localparam logic [2:0] S_PRESSED = 3'd2;
    localparam logic [2:0] S_HELD    = 3'd3;
    localparam logic [2:0] S_LOCKOUT = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DOT_LIM     = CNT_W'(DOT_MAX_CYC);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_MAX_CYC - 1);
    localparam logic [CNT_W-1:0] LETTER_LAST = CNT_W'(LETTER_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] WORD_LAST   = CNT_W'(WORD_GAP_CYC - 1);

    logic             pb_m;
    logic             pb_s;
    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [CNT_W-1:0] press_cnt;
    logic [CNT_W-1:0] press_nx;
    logic [CNT_W-1:0] press_inc;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] gap_nx;
    logic [CNT_W-1:0] gap_inc;
    logic             letter_pend;
    logic             letter_nx;
    logic             word_pend;
    logic             word_nx;
    logic             dot_nx;
    logic             dash_nx;
    logic             held_rel;
    logic             letter_end_nx;
    logic             word_end_nx;
    logic             press_counting;

    // Two-flop synchroniser; everything downstream looks only at pb_s.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pb_m <= 1'b0;
            pb_s <= 1'b0;
        end else begin
            pb_m <= PB;
            pb_s <= pb_m;
        end
    end

    // Both counters saturate instead of wrapping.
    assign press_inc = (press_cnt == CNT_MAX) ? press_cnt : press_cnt + CNT_ONE;
    assign gap_inc   = (gap_cnt == CNT_MAX) ? gap_cnt : gap_cnt + CNT_ONE;

    assign press_counting = (state == S_DEB) || (state == S_PRESSED) ||
                            (state == S_LOCKOUT);

    always_comb begin
        state_nx      = state;
        gap_nx        = gap_cnt;
        letter_nx     = letter_pend;
        word_nx       = word_pend;
        dot_nx        = 1'b0;
        dash_nx       = 1'b0;
        held_rel      = 1'b0;
        letter_end_nx = 1'b0;
        word_end_nx   = 1'b0;

        // Gap thresholds are checked in every state; gap_cnt sits at 0
        // while the key is down, so they cannot fire mid-press.
        if (letter_pend && (gap_cnt == LETTER_LAST)) begin
            letter_end_nx = 1'b1;
            letter_nx     = 1'b0;
        end
        if (word_pend && (gap_cnt == WORD_LAST)) begin
            word_end_nx = 1'b1;
            word_nx     = 1'b0;
        end

        unique case (state)
            S_IDLE: begin
                gap_nx = gap_inc;
                if (pb_s) begin
                    state_nx = S_DEB;
                end
            end
            S_DEB: begin
                gap_nx = gap_inc;
                if (!pb_s) begin
                    state_nx = S_IDLE;
                end else if (press_cnt == DEB_LAST) begin
                    // A confirmed press continues the current letter.
                    state_nx = S_PRESSED;
                    gap_nx   = '0;
                end
            end
            S_PRESSED: begin
                // Release takes priority over reaching the hold limit.
                if (!pb_s) begin
                    state_nx = S_LOCKOUT;
                    if (press_cnt < DOT_LIM) begin
                        dot_nx = 1'b1;
                    end else begin
                        dash_nx = 1'b1;
                    end
                end else if (press_cnt == HOLD_LAST) begin
                    state_nx = S_HELD;
                end
            end
            S_HELD: begin
                if (!pb_s) begin
                    state_nx = S_LOCKOUT;
                    held_rel = 1'b1;
                end
            end
            S_LOCKOUT: begin
                gap_nx = gap_inc;
                if (press_cnt == DEB_LAST) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

`ifndef MORSE_HOLD_CANCEL_EN
        dash_nx = dash_nx | held_rel;
`endif

        // A symbol restarts gap timing and arms both gap events.
        if (dot_nx || dash_nx) begin
            letter_nx = 1'b1;
            word_nx   = 1'b1;
            gap_nx    = '0;
        end

`ifdef MORSE_HOLD_CANCEL_EN
        // An aborted hold also aborts the partial letter.
        if (held_rel) begin
            letter_nx = 1'b0;
            word_nx   = 1'b0;
            gap_nx    = '0;
        end
`endif

        if (state_nx != state) begin
            press_nx = '0;
        end else if (press_counting) begin
            press_nx = press_inc;
        end else begin
            press_nx = press_cnt;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= S_IDLE;
            press_cnt   <= '0;
            gap_cnt     <= '0;
            letter_pend <= 1'b0;
            word_pend   <= 1'b0;
            DPB         <= 1'b0;
            DOT         <= 1'b0;
            DASH        <= 1'b0;
            LETTER_END  <= 1'b0;
            WORD_END    <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            state       <= state_nx;
            press_cnt   <= press_nx;
            gap_cnt     <= gap_nx;
            letter_pend <= letter_nx;
            word_pend   <= word_nx;
            DPB         <= (state_nx == S_PRESSED) || (state_nx == S_HELD);
            DOT         <= dot_nx;
            DASH        <= dash_nx;
            LETTER_END  <= letter_end_nx;
            WORD_END    <= word_end_nx;
            BUSY        <= (state_nx != S_IDLE) || letter_nx || word_nx;
        end
    end

`ifdef MORSE_HOLD_CANCEL_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            CANCEL <= 1'b0;
        end else begin
            CANCEL <= held_rel;
        end
    end
`else
    assign CANCEL = 1'b0;
`endif

endmodule

// File: tb/tb_morse_key_classifier.sv
// Testbench for morse_key_classifier: directed scenarios plus random key
// activity, compared each cycle against a timestamp-based reference model.

module tb_morse_key_classifier;

    localparam int CW = 8;
    localparam int DB = 4;
    localparam int DM = 16;
    localparam int HM = 64;
    localparam int LG = 32;
    localparam int WG = 96;

    localparam int P_IDLE = 0;
    localparam int P_DEB  = 1;
    localparam int P_PR   = 2;
    localparam int P_HELD = 3;
    localparam int P_LOCK = 4;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic PB = 1'b0;
    logic DPB, DOT, DASH, LETTER_END, WORD_END, CANCEL, BUSY;

    int vectors = 0;
    int miscompares = 0;

    // reference model state: phase plus entry/restart timestamps
    int n = 0;
    int ph;
    int t_ph;
    int t_gap;
    bit lp, wp, s1, s2;
    bit e_dpb, e_dot, e_dash, e_le, e_we, e_can, e_busy;

    // per-scenario observed pulse tallies
    int c_dot, c_dash, c_le, c_we, c_can, c_dpb;

    morse_key_classifier #(
        .CNT_W(CW),
        .DEBOUNCE_CYC(DB),
        .DOT_MAX_CYC(DM),
        .HOLD_MAX_CYC(HM),
        .LETTER_GAP_CYC(LG),
        .WORD_GAP_CYC(WG)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .PB(PB),
        .DPB(DPB),
        .DOT(DOT),
        .DASH(DASH),
        .LETTER_END(LETTER_END),
        .WORD_END(WORD_END),
        .CANCEL(CANCEL),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    function void m_reset();
        ph     = P_IDLE;
        t_ph   = n;
        t_gap  = n;
        lp     = 1'b0;
        wp     = 1'b0;
        s1     = 1'b0;
        s2     = 1'b0;
        e_dpb  = 1'b0;
        e_dot  = 1'b0;
        e_dash = 1'b0;
        e_le   = 1'b0;
        e_we   = 1'b0;
        e_can  = 1'b0;
        e_busy = 1'b0;
    endfunction

    // One clock edge: time in phase and time since the last gap restart
    // are differences of timestamps.
    function void m_step(bit pb);
        int  in_ph;
        int  gap;
        bit  ps;
        bit  sym;
        ps     = s2;
        in_ph  = n - t_ph;
        gap    = (ph == P_PR || ph == P_HELD) ? 0 : n - t_gap;
        sym    = 1'b0;
        e_dot  = 1'b0;
        e_dash = 1'b0;
        e_le   = 1'b0;
        e_we   = 1'b0;
        e_can  = 1'b0;
        if (lp && gap == LG - 1) begin
            e_le = 1'b1;
            lp   = 1'b0;
        end
        if (wp && gap == WG - 1) begin
            e_we = 1'b1;
            wp   = 1'b0;
        end
        case (ph)
            P_IDLE: if (ps) begin
                ph = P_DEB;
                t_ph = n + 1;
            end
            P_DEB: if (!ps) begin
                ph = P_IDLE;
                t_ph = n + 1;
            end else if (in_ph == DB - 1) begin
                ph = P_PR;
                t_ph = n + 1;
            end
            P_PR: if (!ps) begin
                ph = P_LOCK;
                t_ph = n + 1;
                sym = 1'b1;
                if (in_ph < DM) e_dot = 1'b1;
                else e_dash = 1'b1;
            end else if (in_ph == HM - 1) begin
                ph = P_HELD;
                t_ph = n + 1;
            end
            P_HELD: if (!ps) begin
                ph = P_LOCK;
                t_ph = n + 1;
`ifdef MORSE_HOLD_CANCEL_EN
                e_can = 1'b1;
                lp = 1'b0;
                wp = 1'b0;
                t_gap = n + 1;
`else
                e_dash = 1'b1;
                sym = 1'b1;
`endif
            end
            default: if (in_ph == DB - 1) begin
                ph = P_IDLE;
                t_ph = n + 1;
            end
        endcase
        if (sym) begin
            lp = 1'b1;
            wp = 1'b1;
            t_gap = n + 1;
        end
        e_dpb  = (ph == P_PR) || (ph == P_HELD);
        e_busy = (ph != P_IDLE) || lp || wp;
        s2 = s1;
        s1 = pb;
        n++;
    endfunction

    task automatic check();
        logic [6:0] got;
        logic [6:0] want;
        got  = {DPB, DOT, DASH, LETTER_END, WORD_END, CANCEL, BUSY};
        want = {e_dpb, e_dot, e_dash, e_le, e_we, e_can, e_busy};
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL outs cyc=%0d got=%b want=%b (dpb,dot,dash,le,we,can,busy)",
                   n, got, want);
        end
    endtask

    task automatic expect_eq(string tag, int got, int want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic clr();
        c_dot  = 0;
        c_dash = 0;
        c_le   = 0;
        c_we   = 0;
        c_can  = 0;
        c_dpb  = 0;
    endtask

    task automatic tick(bit b);
        PB = b;
        @(posedge CLK);
        m_step(b);
        #1;
        check();
        c_dot  += int'(DOT);
        c_dash += int'(DASH);
        c_le   += int'(LETTER_END);
        c_we   += int'(WORD_END);
        c_can  += int'(CANCEL);
        c_dpb  += int'(DPB);
    endtask

    task automatic hold(bit b, int k);
        for (int i = 0; i < k; i++) tick(b);
    endtask

    initial begin
        RESET = 1'b1;
        PB    = 1'b0;
        #2;
        m_reset();
        check();
        repeat (2) @(posedge CLK);
        #2;
        RESET = 1'b0;
        m_reset();

        // bounce rejection
        clr();
        hold(1'b1, 3);
        hold(1'b0, 10);
        for (int i = 0; i < 10; i++) begin
            hold(1'b1, 2);
            hold(1'b0, 2);
        end
        hold(1'b0, 10);
        expect_eq("bounce_dpb", c_dpb, 0);
        expect_eq("bounce_sym", c_dot + c_dash, 0);
        expect_eq("bounce_busy", int'(BUSY), 0);

        // single dot and its gap events
        clr();
        hold(1'b1, 10);
        hold(1'b0, 110);
        expect_eq("dot_dot", c_dot, 1);
        expect_eq("dot_dash", c_dash, 0);
        expect_eq("dot_dpb", c_dpb, 6);
        expect_eq("dot_le", c_le, 1);
        expect_eq("dot_we", c_we, 1);
        expect_eq("dot_busy", int'(BUSY), 0);

        // dash
        clr();
        hold(1'b1, 30);
        hold(1'b0, 110);
        expect_eq("dash_dash", c_dash, 1);
        expect_eq("dash_dot", c_dot, 0);

        // boundary: release at press_cnt 15 then 16
        clr();
        hold(1'b1, 20);
        hold(1'b0, 110);
        expect_eq("b15_dot", c_dot, 1);
        expect_eq("b15_dash", c_dash, 0);
        clr();
        hold(1'b1, 21);
        hold(1'b0, 110);
        expect_eq("b16_dash", c_dash, 1);
        expect_eq("b16_dot", c_dot, 0);

        // key chatter during lockout
        clr();
        hold(1'b1, 10);
        hold(1'b0, 2);
        for (int i = 0; i < 3; i++) begin
            hold(1'b1, 1);
            hold(1'b0, 1);
        end
        hold(1'b0, 110);
        expect_eq("lock_dot", c_dot, 1);
        expect_eq("lock_dpb", c_dpb, 6);

        // dot and dash inside one letter
        clr();
        hold(1'b1, 10);
        hold(1'b0, 10);
        hold(1'b1, 30);
        expect_eq("intra_le_mid", c_le, 0);
        hold(1'b0, 40);
        expect_eq("intra_dot", c_dot, 1);
        expect_eq("intra_dash", c_dash, 1);
        expect_eq("intra_le", c_le, 1);
        hold(1'b0, 80);

        // long hold into HELD
        clr();
        hold(1'b1, 100);
        expect_eq("held_dpb", int'(DPB), 1);
        hold(1'b0, 120);
`ifdef MORSE_HOLD_CANCEL_EN
        expect_eq("held_can", c_can, 1);
        expect_eq("held_dash", c_dash, 0);
        expect_eq("held_le", c_le, 0);
        expect_eq("held_we", c_we, 0);
`else
        expect_eq("held_dash", c_dash, 1);
        expect_eq("held_can", c_can, 0);
        expect_eq("held_le", c_le, 1);
`endif

        // reset in the middle of a press
        hold(1'b1, 14);
        expect_eq("rst_pre_dpb", int'(DPB), 1);
        #2;
        RESET = 1'b1;
        #1;
        m_reset();
        check();
        PB = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        RESET = 1'b0;
        m_reset();
        clr();
        hold(1'b0, 120);
        expect_eq("rst_dot", c_dot + c_dash, 0);
        expect_eq("rst_gap", c_le + c_we, 0);

        // random key activity
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) == 0)
                hold(1'b1, $urandom_range(60, 90));
            else
                hold(1'b1, $urandom_range(1, 30));
            hold(1'b0, $urandom_range(1, 45));
        end
        hold(1'b0, 120);
        expect_eq("rand_idle_busy", int'(BUSY), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/morse_key_classifier.md
Name: morse_key_classifier

Overview:
Parametrised successor to the single-button short/long decoder in the Morse front end. It takes the raw key input, synchronises and debounces it, and times each press to emit a one-cycle DOT or DASH pulse. It also times the idle gaps between presses to emit LETTER_END and WORD_END pulses, so the downstream symbol assembler needs no timers of its own.

Parameters:
- CNT_W, 28: width of the press and gap counters; every threshold below must be < 2**CNT_W.
- DEBOUNCE_CYC, 8388608: stable-high cycles required to accept a press; also the release lockout length.
- DOT_MAX_CYC, 16777216: a press duration below this is a DOT; at or above it is a DASH.
- HOLD_MAX_CYC, 33554432: a press reaching this duration enters HELD.
- LETTER_GAP_CYC, 16777216: idle cycles after a symbol that close the current letter.
- WORD_GAP_CYC, 67108864: idle cycles after a symbol that close the current word.
- Legal ordering: DEBOUNCE_CYC < DOT_MAX_CYC < HOLD_MAX_CYC, and DEBOUNCE_CYC < LETTER_GAP_CYC < WORD_GAP_CYC.

Ports:
- CLK, input, 1: clock.
- RESET, input, 1: asynchronous, active-high reset.
- PB, input, 1: raw key, asynchronous to CLK.
- DPB, output, 1: debounced key level; high in PRESSED and HELD only.
- DOT, output, 1: one-cycle pulse.
- DASH, output, 1: one-cycle pulse.
- LETTER_END, output, 1: one-cycle pulse.
- WORD_END, output, 1: one-cycle pulse.
- CANCEL, output, 1: one-cycle pulse; tied 0 unless MORSE_HOLD_CANCEL_EN is defined.
- BUSY, output, 1: high when state != IDLE, or when any gap flag is pending.

Behaviour:
- Reset (clock: CLK; reset: RESET, asynchronous, active-high):
  - State goes to IDLE.
  - Both counters, both synchroniser flops, both pending flags and all outputs go to 0.
  - A reset mid-press or mid-gap discards any in-progress symbol and all pending gap events.
- Synchroniser: 2-flop chain, PB to pb_s. All decisions use pb_s. Input-to-pb_s latency is 2 cycles.
- Outputs: all registered. Each pulse is asserted in the cycle after the decision edge, for exactly one cycle.
- press_cnt (CNT_W bits), saturating:
  - Cleared on every state entry.
  - Increments in DEB, PRESSED and LOCKOUT.
  - Frozen in IDLE and HELD.
- States:
  - IDLE:
    - pb_s=1 -> DEB.
  - DEB:
    - pb_s=0 -> IDLE (bounce rejected; no output).
    - press_cnt==DEBOUNCE_CYC-1 with pb_s=1 -> PRESSED, DPB<=1.
  - PRESSED:
    - pb_s=0 -> LOCKOUT, DPB<=0. Emit DOT if press_cnt < DOT_MAX_CYC, otherwise DASH.
    - press_cnt==HOLD_MAX_CYC-1 with pb_s=1 -> HELD.
    - If both conditions hold in the same cycle, release wins.
  - HELD:
    - pb_s=0 -> LOCKOUT, DPB<=0, emit DASH (default build).
  - LOCKOUT:
    - pb_s is ignored.
    - press_cnt==DEBOUNCE_CYC-1 -> IDLE. If pb_s=1 at that point, DEB is entered on the next cycle.
- Gap tracking:
  - letter_pend and word_pend are set, and gap_cnt is cleared, in the cycle a DOT or DASH is emitted.
  - gap_cnt (CNT_W bits, saturating) increments in IDLE, DEB and LOCKOUT.
  - gap_cnt is cleared on entry to PRESSED. A confirmed press therefore continues the current letter.
  - A rejected bounce does not clear gap_cnt.
  - gap_cnt==LETTER_GAP_CYC-1 with letter_pend=1 -> LETTER_END, clear letter_pend.
  - gap_cnt==WORD_GAP_CYC-1 with word_pend=1 -> WORD_END, clear word_pend.
  - Given the legal ordering, LETTER_END always precedes WORD_END; they never coincide.
  - No gap pulses occur before the first symbol after reset.
- Counter saturation: no wrap. A counter at 2**CNT_W-1 holds its value.

Optional Feature:
MORSE_HOLD_CANCEL_EN
- Defined:
  - Release from HELD emits CANCEL instead of DASH.
  - letter_pend and word_pend are cleared and gap_cnt is reset, so the aborted press and any partial letter produce no further gap pulses.
  - The downstream assembler drops its partial letter on CANCEL.
- Undefined:
  - HELD behaves as a long DASH.
  - CANCEL is constant 0.

Test Plan:
All scenarios use CNT_W=8, DEBOUNCE_CYC=4, DOT_MAX_CYC=16, HOLD_MAX_CYC=64, LETTER_GAP_CYC=32, WORD_GAP_CYC=96.
- Bounce: PB high 3 cycles, then low -> no DPB, no pulses, BUSY returns to 0; repeat with 2-cycle glitches 10 times -> same.
- Dot: PB high 10 cycles then low -> DPB high about 6 cycles, exactly one DOT, no DASH. After release, LETTER_END once at gap_cnt 31 and WORD_END once at gap_cnt 95, then BUSY=0.
- Dash, boundary, and lockout:
  - Press held 30 cycles -> one DASH.
  - Press measuring exactly press_cnt=15 at release -> DOT; press_cnt=16 -> DASH.
  - PB toggling during LOCKOUT -> ignored.
- Intra-letter: dot, 10 idle cycles, dash, 40 idle cycles -> DOT, DASH, one LETTER_END, no LETTER_END between the symbols.
- Held: PB high 100 cycles -> HELD reached, press_cnt frozen. On release: DASH (default build), or CANCEL with no LETTER_END/WORD_END (MORSE_HOLD_CANCEL_EN).
- Reset mid-press: assert RESET at PRESSED cycle 8 -> all outputs 0 immediately. After release, no DOT and no gap pulses.
